// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end with a one-entry holding buffer
// and last-bit bypass so back-to-back words stream out without gaps.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           st_q, st_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sh_shifted;
    logic             accept;
    logic             last_bit;

    // Handshake decode; ready only depends on reset and buffer occupancy
    assign din_ready = !reset && !hold_full_q;
    assign accept    = din_valid && din_ready;
    assign last_bit  = (cnt_q == LAST_IDX);

    // Shift one position toward the output end of the register
    always_comb begin
        sh_shifted = sh_q;
        if (MSB_FIRST) begin
            sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
        end else begin
            sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
        end
    end

    // State register plus datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q        <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Next-state: load, shift, drain buffer or bypass on the last bit
    always_comb begin
        st_d        = st_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        case (st_q)
            IDLE: begin
                if (accept) begin
                    sh_d  = din;
                    cnt_d = '0;
                    st_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    sh_d  = sh_shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (accept) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    sh_d  = din;
                    cnt_d = '0;
                end else begin
                    st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // Output decode from registered state only
    assign x_valid   = (st_q == SHIFT);
    assign x         = x_valid ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
    assign busy      = x_valid || hold_full_q;
    assign word_done = x_valid && last_bit;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed testbench for bit_serializer (MSB-first and LSB-first instances).
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din_m, din_l;
    logic       din_valid_m, din_valid_l;
    logic       din_ready_m, din_ready_l;
    logic       x_m, x_l;
    logic       x_valid_m, x_valid_l;
    logic       busy_m, busy_l;
    logic       word_done_m, word_done_l;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] hist;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .reset(reset), .din(din_m), .din_valid(din_valid_m),
        .din_ready(din_ready_m), .x(x_m), .x_valid(x_valid_m),
        .busy(busy_m), .word_done(word_done_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .din(din_l), .din_valid(din_valid_l),
        .din_ready(din_ready_l), .x(x_l), .x_valid(x_valid_l),
        .busy(busy_l), .word_done(word_done_l)
    );

    // Count one comparison and report a mismatch
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag);
        check({tag, ".x"}, 16'(x_m), 16'h0);
        check({tag, ".x_valid"}, 16'(x_valid_m), 16'h0);
        check({tag, ".busy"}, 16'(busy_m), 16'h0);
        check({tag, ".word_done"}, 16'(word_done_m), 16'h0);
    endtask

    initial begin
        logic [15:0] stream;
        logic [7:0]  w;
        logic        exp_z;

        // Reset with din_valid high: no accept, ready low
        reset = 1'b1; din_m = 8'h55; din_valid_m = 1'b1; din_l = 8'h00; din_valid_l = 1'b0;
        #1;
        check("rst.ready0", 16'(din_ready_m), 16'h0);
        step();
        check("rst.ready1", 16'(din_ready_m), 16'h0);
        check("rst.x_valid1", 16'(x_valid_m), 16'h0);
        step();
        check("rst.ready2", 16'(din_ready_m), 16'h0);
        idle_check("rst.out");
        reset = 1'b0; din_valid_m = 1'b0;
        #1;
        check("rst.ready_after", 16'(din_ready_m), 16'h1);
        step();
        idle_check("rst.idle");
        check("rst.lsb_busy", 16'(busy_l), 16'h0);

        // Single word 1001_0110, MSB first
        w = 8'b1001_0110;
        din_m = w; din_valid_m = 1'b1;
        step();
        din_valid_m = 1'b0; din_m = 8'hFF;
        for (int c = 1; c <= 8; c++) begin
            check("single.x", 16'(x_m), 16'(w[8-c]));
            check("single.x_valid", 16'(x_valid_m), 16'h1);
            check("single.word_done", 16'(word_done_m), 16'(c == 8));
            step();
        end
        idle_check("single.after");

        // Back-to-back A5 then 3C with din_valid held
        stream = 16'hA53C;
        din_m = 8'hA5; din_valid_m = 1'b1;
        step();
        for (int c = 1; c <= 17; c++) begin
            check("b2b.x_valid", 16'(x_valid_m), 16'(c <= 16));
            if (c <= 16) check("b2b.x", 16'(x_m), 16'(stream[16-c]));
            check("b2b.ready", 16'(din_ready_m), 16'((c >= 2 && c <= 8) ? 0 : 1));
            check("b2b.word_done", 16'(word_done_m), 16'(c == 8 || c == 16));
            if (c == 1) din_m = 8'h3C;
            if (c == 2) din_valid_m = 1'b0;
            if (c < 17) step();
        end

        // Last-bit bypass: 5A then FF accepted on the last-bit edge
        stream = 16'h5AFF;
        din_m = 8'h5A; din_valid_m = 1'b1;
        step();
        din_valid_m = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            check("byp.x_valid", 16'(x_valid_m), 16'(c <= 16));
            if (c <= 16) check("byp.x", 16'(x_m), 16'(stream[16-c]));
            check("byp.ready", 16'(din_ready_m), 16'h1);
            check("byp.busy", 16'(busy_m), 16'(c <= 16));
            if (c == 8) begin din_m = 8'hFF; din_valid_m = 1'b1; end
            if (c == 9) din_valid_m = 1'b0;
            if (c < 17) step();
        end

        // Same word 01 on both instances: LSB-first vs MSB-first
        din_m = 8'h01; din_l = 8'h01; din_valid_m = 1'b1; din_valid_l = 1'b1;
        step();
        din_valid_m = 1'b0; din_valid_l = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("lsb.x", 16'(x_l), 16'(c == 1));
            check("lsb.x_valid", 16'(x_valid_l), 16'h1);
            check("lsb.word_done", 16'(word_done_l), 16'(c == 8));
            check("msb.x", 16'(x_m), 16'(c == 8));
            step();
        end
        check("lsb.after_valid", 16'(x_valid_l), 16'h0);
        check("lsb.after_busy", 16'(busy_l), 16'h0);

        // Reset mid-word with 3C buffered: nothing completes, 3C never sent
        din_m = 8'hA5; din_valid_m = 1'b1;
        step();
        din_m = 8'h3C;
        step();
        din_valid_m = 1'b0;
        check("mid.ready_full", 16'(din_ready_m), 16'h0);
        step();
        check("mid.busy_before", 16'(busy_m), 16'h1);
        check("mid.x3", 16'(x_m), 16'h1);
        reset = 1'b1;
        step();
        idle_check("mid.reset");
        check("mid.ready_in_reset", 16'(din_ready_m), 16'h0);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            check("mid.no_send", 16'(x_valid_m), 16'h0);
            check("mid.no_done", 16'(word_done_m), 16'h0);
        end
        check("mid.ready_back", 16'(din_ready_m), 16'h1);

        // End-to-end: 1001_0000 into a 10010 detector, hit on fifth bit
        hist = 4'h0;
        din_m = 8'b1001_0000; din_valid_m = 1'b1;
        step();
        din_valid_m = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp_z = (c == 5);
            check("det.z", 16'(x_valid_m && hist == 4'b1001 && x_m == 1'b0), 16'(exp_z));
            if (x_valid_m) hist = {hist[2:0], x_m};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
